// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, samples synchronized rows,
// debounces whole scan frames and reports a single committed key with press/release pulses.
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release,
  output logic       multi_key
);

  localparam int unsigned CntW = $clog2(SCAN_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_CYCLES - 1);
  localparam logic [3:0] DebMax = 4'(DEBOUNCE_SCANS);

  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [CntW-1:0] cnt;
  logic [1:0]      col_idx;
  logic [4:0]      acc_count;
  logic            acc_found;
  logic [3:0]      acc_code;
  logic            cand_valid;
  logic [3:0]      cand_code;
  logic [3:0]      stable;

  logic [3:0] pressed;
  logic [2:0] sample_count;
  logic [1:0] low_row;
  logic [4:0] frame_count;
  logic       frame_found;
  logic [3:0] frame_code;
  logic       frame_multi;
  logic       res_valid;
  logic [3:0] res_code;
  logic       res_same;
  logic [3:0] stable_next;
  logic       commit;

  // Running totals include the column being sampled right now, so the last column
  // sample yields the complete frame result combinationally.
  always_comb begin
    pressed      = ~row_sync;
    sample_count = {2'b00, pressed[0]} + {2'b00, pressed[1]} +
                   {2'b00, pressed[2]} + {2'b00, pressed[3]};
    low_row = 2'd0;
    if (pressed[0])      low_row = 2'd0;
    else if (pressed[1]) low_row = 2'd1;
    else if (pressed[2]) low_row = 2'd2;
    else if (pressed[3]) low_row = 2'd3;
    frame_count = acc_count + {2'b00, sample_count};
    frame_found = acc_found | (|pressed);
    frame_code  = acc_found ? acc_code : {col_idx, low_row};
    frame_multi = (frame_count > 5'd1);
    res_valid   = (frame_count == 5'd1);
    res_code    = res_valid ? frame_code : 4'd0;
    res_same    = ({res_valid, res_code} == {cand_valid, cand_code});
    if (!res_same)             stable_next = 4'd1;
    else if (stable == DebMax) stable_next = stable;
    else                       stable_next = stable + 4'd1;
    commit = !frame_multi && (stable_next == DebMax) &&
             ((res_valid != key_valid) || (res_valid && (res_code != key_code)));
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      row_meta    <= 4'hF;
      row_sync    <= 4'hF;
      cnt         <= '0;
      col_idx     <= 2'd0;
      col         <= 4'b1110;
      acc_count   <= 5'd0;
      acc_found   <= 1'b0;
      acc_code    <= 4'd0;
      cand_valid  <= 1'b0;
      cand_code   <= 4'd0;
      stable      <= 4'd0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      row_meta    <= row;
      row_sync    <= row_meta;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (cnt == CntLast) begin
        cnt     <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[2:0], col[3]};
        if (col_idx == 2'd3) begin
          acc_count <= 5'd0;
          acc_found <= 1'b0;
          acc_code  <= 4'd0;
          multi_key <= frame_multi;
          // Multi-key frames are ignored by the debouncer entirely.
          if (!frame_multi) begin
            cand_valid <= res_valid;
            cand_code  <= res_code;
            stable     <= stable_next;
          end
          if (commit) begin
            if (res_valid) begin
              key_code  <= res_code;
              key_valid <= 1'b1;
              key_press <= 1'b1;
            end else begin
              key_valid   <= 1'b0;
              key_release <= 1'b1;
            end
          end
        end else begin
          acc_count <= frame_count;
          acc_found <= frame_found;
          acc_code  <= frame_code;
        end
      end else begin
        cnt <= cnt + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: frame-level key-mask model, directed frame table,
// mid-debounce reset sequence and randomized key traffic.
module tb_keypad_scanner;

  localparam int unsigned S = 8;
  localparam int unsigned D = 3;
  localparam int unsigned F = 4 * S;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic       key_release;
  logic       multi_key;

  logic [15:0] mask = 16'h0000;
  logic        row_force = 1'b1;

  always #5 clk = ~clk;

  // Keypad model: a held key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    if (row_force) row = 4'h0;
    else begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (col[c] == 1'b0 && mask[c*4+r]) row[r] = 1'b0;
    end
  end

  keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_SCANS(D)) dut (
    .clk        (clk),
    .clear      (clear),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_press  (key_press),
    .key_release(key_release),
    .multi_key  (multi_key)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference state, kept at the level of whole frames and key masks.
  bit m_cand_v;
  int m_cand_c;
  int m_stable;
  bit m_valid;
  int m_code;
  bit m_multi;
  bit e_press;
  bit e_rel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_cand_v = 0; m_cand_c = 0; m_stable = 0;
    m_valid = 0; m_code = 0; m_multi = 0;
    e_press = 0; e_rel = 0; cyc = 0;
  endtask

  task automatic model_frame(input logic [15:0] m);
    int n;
    bit rv;
    int rc;
    n = $countones(m);
    m_multi = (n > 1);
    if (n <= 1) begin
      rv = (n == 1);
      rc = rv ? lowest(m) : 0;
      if (rv == m_cand_v && rc == m_cand_c) begin
        if (m_stable < D) m_stable++;
      end else begin
        m_cand_v = rv; m_cand_c = rc; m_stable = 1;
      end
      if (m_stable == D && (m_cand_v != m_valid || (m_cand_v && m_cand_c != m_code))) begin
        if (m_cand_v) begin
          m_code = m_cand_c; m_valid = 1; e_press = 1;
        end else begin
          m_valid = 0; e_rel = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] ec;
    ec = ~(4'b0001 << ((cyc / S) % 4));
    chk("col", col, ec);
    chk("key_valid", key_valid, m_valid);
    chk("key_code", key_code, m_code);
    chk("key_press", key_press, e_press);
    chk("key_release", key_release, e_rel);
    chk("multi_key", multi_key, m_multi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    e_press = 0;
    e_rel = 0;
    if (cyc % F == 0) model_frame(mask);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    clear = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    clear = 1'b1;
  endtask

  typedef struct {
    logic [15:0] mask;
    logic        valid;
    logic [3:0]  code;
    logic        press;
    logic        rel;
    logic        multi;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit got;
    int r;
    tbl[0]  = '{16'h0000, 0, 0, 0, 0, 0};
    tbl[1]  = '{16'h0040, 0, 0, 0, 0, 0};
    tbl[2]  = '{16'h0040, 0, 0, 0, 0, 0};
    tbl[3]  = '{16'h0040, 1, 6, 1, 0, 0};
    tbl[4]  = '{16'h0040, 1, 6, 0, 0, 0};
    tbl[5]  = '{16'h0000, 1, 6, 0, 0, 0};
    tbl[6]  = '{16'h0000, 1, 6, 0, 0, 0};
    tbl[7]  = '{16'h0000, 0, 6, 0, 1, 0};
    tbl[8]  = '{16'h0008, 0, 6, 0, 0, 0};
    tbl[9]  = '{16'h0000, 0, 6, 0, 0, 0};
    tbl[10] = '{16'h0008, 0, 6, 0, 0, 0};
    tbl[11] = '{16'h0008, 0, 6, 0, 0, 0};
    tbl[12] = '{16'h0000, 0, 6, 0, 0, 0};
    tbl[13] = '{16'h0008, 0, 6, 0, 0, 0};
    tbl[14] = '{16'h0008, 0, 6, 0, 0, 0};
    tbl[15] = '{16'h0008, 1, 3, 1, 0, 0};
    tbl[16] = '{16'h0004, 1, 3, 0, 0, 0};
    tbl[17] = '{16'h0004, 1, 3, 0, 0, 0};
    tbl[18] = '{16'h0004, 1, 2, 1, 0, 0};
    tbl[19] = '{16'h0204, 1, 2, 0, 0, 1};
    tbl[20] = '{16'h0204, 1, 2, 0, 0, 1};
    tbl[21] = '{16'h0200, 1, 2, 0, 0, 0};
    tbl[22] = '{16'h0200, 1, 2, 0, 0, 0};
    tbl[23] = '{16'h0200, 1, 9, 1, 0, 0};

    // Reset with all rows pulled low, then release.
    do_reset(3);
    row_force = 1'b0;

    // Directed frames: press, release, bounce, key change and rollover.
    for (int i = 0; i < 24; i++) begin
      mask = tbl[i].mask;
      repeat (F) tick();
      chk($sformatf("tbl%0d_valid", i), key_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_code", i), key_code, tbl[i].code);
      chk($sformatf("tbl%0d_press", i), key_press, tbl[i].press);
      chk($sformatf("tbl%0d_release", i), key_release, tbl[i].rel);
      chk($sformatf("tbl%0d_multi", i), multi_key, tbl[i].multi);
    end

    // Reset in the middle of debouncing key 5; the count must restart from zero.
    mask = 16'h0020;
    repeat (2 * F + 5) tick();
    do_reset(1);
    lat = 0;
    got = 0;
    for (int i = 0; i < 4 * F && !got; i++) begin
      tick();
      lat++;
      if (key_press) got = 1;
    end
    chk("press_latency_after_reset", lat, 3 * F);
    chk("press_code_after_reset", key_code, 5);

    // Randomized frame-aligned key traffic against the frame model.
    for (int f = 0; f < 200; f++) begin
      r = $urandom_range(0, 99);
      if (r < 40) mask = mask;
      else if (r < 65) mask = 16'h0000;
      else if (r < 90) mask = 16'h0001 << $urandom_range(0, 15);
      else mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      repeat (F) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
